// File: rtl/packet_pkg.sv
// Packet type shared by the IP blocks, routers and the injection queues of the onoc bus.
// PACKET_W and INJ_FIFO_DEPTH let the bus top size its per-IP injection queues.
package packet_pkg;

    typedef struct packed {
        logic [3:0]  src_id;
        logic [3:0]  dst_id;
        logic [15:0] data;
    } packet_t;

    localparam int PACKET_W       = $bits(packet_t);
    localparam int INJ_FIFO_DEPTH = 8;

endpackage

// File: rtl/ip_inject_fifo.sv
// First-word-fall-through injection queue between an ip_block and its router, with a drop counter.
// Define ONOC_FIFO_STATS_EN to build the high_water occupancy register; otherwise high_water reads 0.
module ip_inject_fifo
    import packet_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PACKET_W-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PACKET_W-1:0]        out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DROP_W-1:0]          drop_count,
    output logic [$clog2(DEPTH):0]     high_water
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PACKET_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [DROP_W-1:0]   drop_q;
    logic                push;
    logic                pop;
    logic                drop;

    // Handshake: a word moves only on a cycle where valid && ready are both high at the rising
    // edge. The generator ignores in_ready, so in_valid while full is a drop, not a stall, and
    // in_ready is a pure function of occupancy (no same-cycle pass-through when full).
    assign out_valid = (cnt_q != '0);
    assign in_ready  = (cnt_q != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop && (drop_q != {DROP_W{1'b1}})) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    assign count      = cnt_q;
    assign drop_count = drop_q;

`ifdef ONOC_FIFO_STATS_EN
    logic [CW-1:0] hw_q;

    // Tracks the next count so the peak includes the occupancy reached on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hw_q <= '0;
        end else if (cnt_d > hw_q) begin
            hw_q <= cnt_d;
        end
    end

    assign high_water = hw_q;
`else
    assign high_water = '0;
`endif

endmodule
